// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the memory controller: access sizes, direction, FSM states.
// Also holds the helper that aligns a byte offset down to the access size.
package mem_ctrl_pkg;

    localparam logic [1:0] DT_BYTE = 2'b00;
    localparam logic [1:0] DT_HALF = 2'b01;
    localparam logic [1:0] DT_WORD = 2'b10;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10
    } state_t;

    // Used when misalignment is not trapped: halfwords drop bit 0, words drop bits 1:0.
    function automatic logic [1:0] force_align(input logic [1:0] dt, input logic [1:0] ofs);
        case (dt)
            DT_BYTE: return ofs;
            DT_HALF: return {ofs[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for a big-endian 32-bit word: read extraction with sign/zero fill,
// per-byte write enables and positioned write bytes. Lane k is byte address base+k (bits 31-8k).
module mem_lane_align
    import mem_ctrl_pkg::*;
(
    input  logic [1:0]  dtype,
    input  logic        sign,
    input  logic [1:0]  ofs,
    input  logic [31:0] rbytes,
    input  logic [31:0] wdata,
    output logic [31:0] rd_val,
    output logic [3:0]  wr_en,
    output logic [31:0] wr_bytes,
    output logic        misaligned
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        rd_val     = '0;
        wr_en      = '0;
        wr_bytes   = '0;
        misaligned = 1'b0;
        sel_byte   = '0;
        sel_half   = '0;

        case (dtype)
            DT_BYTE: begin
                case (ofs)
                    2'd0:    sel_byte = rbytes[31:24];
                    2'd1:    sel_byte = rbytes[23:16];
                    2'd2:    sel_byte = rbytes[15:8];
                    default: sel_byte = rbytes[7:0];
                endcase
                rd_val   = {{24{sign & sel_byte[7]}}, sel_byte};
                wr_en    = 4'b0001 << ofs;
                // Replicated on every lane; only the enabled lane is stored.
                wr_bytes = {4{wdata[7:0]}};
            end
            DT_HALF: begin
                misaligned = ofs[0];
                sel_half   = ofs[1] ? rbytes[15:0] : rbytes[31:16];
                rd_val     = {{16{sign & sel_half[15]}}, sel_half};
                wr_en      = ofs[1] ? 4'b1100 : 4'b0011;
                wr_bytes   = {2{wdata[15:0]}};
            end
            default: begin
                misaligned = (ofs != 2'b00);
                rd_val     = rbytes;
                wr_en      = 4'b1111;
                wr_bytes   = wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// Latency-controlled big-endian byte memory with MOV/MOC handshake and sized accesses.
// Define MEM_CTRL_ALIGN_CHECK_EN to trap misaligned accesses; otherwise they align down.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int DEPTH   = 512,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        mov,
    input  logic        rw,
    input  logic [1:0]  dtype,
    input  logic        sign,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        moc,
    output logic        align_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] cnt;
    logic          commit;

    logic [AW-1:0] idx_q;
    logic          rw_q;
    logic [1:0]    dtype_q;
    logic          sign_q;
    logic [31:0]   wdata_q;

    logic [7:0]    mem [DEPTH];

    logic [AW-1:0] base;
    logic [1:0]    ofs;
    logic [31:0]   word_rd;
    logic [31:0]   rd_val;
    logic [31:0]   wr_bytes;
    logic [3:0]    wr_en;
    logic          misaligned;

    // Address bits above the array size wrap and are intentionally dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[31:AW];

    assign base = {idx_q[AW-1:2], 2'b00};

`ifdef MEM_CTRL_ALIGN_CHECK_EN
    assign ofs = idx_q[1:0];
`else
    assign ofs = force_align(dtype_q, idx_q[1:0]);
`endif

    assign word_rd = {mem[base], mem[base + AW'(1)], mem[base + AW'(2)], mem[base + AW'(3)]};

    mem_lane_align u_lane (
        .dtype      (dtype_q),
        .sign       (sign_q),
        .ofs        (ofs),
        .rbytes     (word_rd),
        .wdata      (wdata_q),
        .rd_val     (rd_val),
        .wr_en      (wr_en),
        .wr_bytes   (wr_bytes),
        .misaligned (misaligned)
    );

    always_comb begin
        next_state = state;
        commit     = 1'b0;
        case (state)
            IDLE: if (mov) next_state = WAIT;
            WAIT: begin
                if (cnt == '0) begin
                    commit     = 1'b1;
                    next_state = DONE;
                end
            end
            DONE: if (!mov) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && mov)
                cnt <= CW'(LATENCY - 1);
            else if (state == WAIT && cnt != '0)
                cnt <= cnt - CW'(1);
        end
    end

    // Request fields are captured once at acceptance and ignored afterwards.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            idx_q   <= '0;
            rw_q    <= RW_READ;
            dtype_q <= DT_BYTE;
            sign_q  <= 1'b0;
            wdata_q <= '0;
        end else if (state == IDLE && mov) begin
            idx_q   <= addr[AW-1:0];
            rw_q    <= rw;
            dtype_q <= dtype;
            sign_q  <= sign;
            wdata_q <= wdata;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            rdata <= '0;
        end else if (commit) begin
            if (misaligned)
                rdata <= '0;
            else if (rw_q == RW_READ)
                rdata <= rd_val;
        end
    end

`ifdef MEM_CTRL_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge clr) begin
        if (!clr)
            align_err <= 1'b0;
        else if (commit)
            align_err <= misaligned;
    end
`else
    assign align_err = 1'b0;
`endif

    // Storage has no reset; reset holds state in IDLE so no commit can occur.
    always_ff @(posedge clk) begin
        if (commit && rw_q == RW_WRITE && !misaligned) begin
            for (int k = 0; k < 4; k++) begin
                if (wr_en[k])
                    mem[base + AW'(k)] <= wr_bytes[31 - 8*k -: 8];
            end
        end
    end

    assign moc = (state == DONE);

endmodule

// File: tb/tb_mem_ctrl.sv
// Randomized self-checking bench for mem_ctrl against a byte-array reference model.
// Honours MEM_CTRL_ALIGN_CHECK_EN the same way as the design build.
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    localparam int DEPTH    = 512;
    localparam int LATENCY  = 2;
    localparam int MAX_WAIT = 20;

    logic        clk;
    logic        clr;
    logic        mov;
    logic        rw;
    logic [1:0]  dtype;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        moc;
    logic        align_err;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]  ref_mem [DEPTH];
    logic [31:0] exp_rdata = '0;
    logic        exp_err   = 1'b0;

    mem_ctrl #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk       (clk),
        .clr       (clr),
        .mov       (mov),
        .rw        (rw),
        .dtype     (dtype),
        .sign      (sign),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .moc       (moc),
        .align_err (align_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: memory is a flat big-endian byte array, accesses are sz consecutive bytes.
    function automatic void model_access(input logic r, input logic [1:0] dt, input logic sg,
                                         input logic [31:0] a, input logic [31:0] wd);
        int          sz;
        int          idx;
        logic [31:0] v;
        sz  = (dt == 2'b00) ? 1 : (dt == 2'b01) ? 2 : 4;
        idx = int'(a % DEPTH);
        if (idx % sz != 0) begin
`ifdef MEM_CTRL_ALIGN_CHECK_EN
            exp_err   = 1'b1;
            exp_rdata = '0;
            return;
`else
            idx = idx - (idx % sz);
`endif
        end
        exp_err = 1'b0;
        if (r) begin
            v = '0;
            for (int i = 0; i < sz; i++)
                v = (v << 8) | 32'(ref_mem[idx + i]);
            if (sz < 4 && sg && v[8*sz - 1])
                v = v | (32'hFFFF_FFFF << (8*sz));
            exp_rdata = v;
        end else begin
            for (int i = 0; i < sz; i++)
                ref_mem[idx + i] = 8'(wd >> (8*(sz - 1 - i)));
        end
    endfunction

    task automatic applyStimulus(input logic r, input logic [1:0] dt, input logic sg,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 input int hold, input bit drop_early);
        int lat;
        bit seen;
        @(negedge clk);
        rw = r; dtype = dt; sign = sg; addr = a; wdata = wd; mov = 1'b1;
        model_access(r, dt, sg, a, wd);
        seen = 1'b0;
        lat  = 0;
        for (int n = 1; n <= MAX_WAIT && !seen; n++) begin
            @(posedge clk); #1;
            if (moc) begin
                seen = 1'b1;
                lat  = n;
            end else begin
                addr  = $urandom;
                wdata = $urandom;
                dtype = 2'($urandom);
                sign  = 1'($urandom);
                rw    = 1'($urandom);
                if (drop_early) mov = 1'b0;
            end
        end
        if (!seen) begin
            checkOutput("moc_timeout", {31'b0, moc}, 32'd1);
            mov = 1'b0;
            repeat (LATENCY + 3) @(posedge clk);
            return;
        end
        checkOutput("latency", lat, LATENCY + 1);
        checkOutput("rdata", rdata, exp_rdata);
        checkOutput("align_err", {31'b0, align_err}, {31'b0, exp_err});
        if (!drop_early) begin
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); #1;
                checkOutput("moc_hold", {31'b0, moc}, 32'd1);
            end
        end
        mov = 1'b0;
        @(posedge clk); #1;
        checkOutput("moc_fall", {31'b0, moc}, 32'd0);
    endtask

    initial begin
        bit spur;
        clr = 1'b1; mov = 1'b1; rw = RW_READ; dtype = DT_WORD; sign = 1'b0;
        addr = '0; wdata = '0;
        #2 clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_moc", {31'b0, moc}, 32'd0);
        checkOutput("rst_rdata", rdata, 32'd0);
        checkOutput("rst_align_err", {31'b0, align_err}, 32'd0);
        @(negedge clk);
        mov = 1'b0;
        clr = 1'b1;
        spur = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (moc) spur = 1'b1;
        end
        checkOutput("no_spurious_moc", {31'b0, spur}, 32'd0);

        for (int w = 0; w < DEPTH / 4; w++)
            applyStimulus(RW_WRITE, DT_WORD, 1'b0, 32'(w * 4), $urandom, 0, 1'b0);

        applyStimulus(RW_WRITE, DT_WORD, 1'b0, 32'h10, 32'h8123_45F6, 0, 1'b0);
        applyStimulus(RW_READ,  DT_WORD, 1'b0, 32'h10, 32'h0, 0, 1'b0);
        checkOutput("tp_word", rdata, 32'h8123_45F6);
        applyStimulus(RW_READ,  DT_BYTE, 1'b1, 32'h13, 32'h0, 0, 1'b0);
        checkOutput("tp_byte13_s", rdata, 32'hFFFF_FFF6);
        applyStimulus(RW_READ,  DT_BYTE, 1'b1, 32'h11, 32'h0, 0, 1'b0);
        checkOutput("tp_byte11_s", rdata, 32'h0000_0023);
        applyStimulus(RW_READ,  DT_HALF, 1'b1, 32'h10, 32'h0, 0, 1'b0);
        checkOutput("tp_half_s", rdata, 32'hFFFF_8123);
        applyStimulus(RW_READ,  DT_HALF, 1'b0, 32'h10, 32'h0, 0, 1'b0);
        checkOutput("tp_half_z", rdata, 32'h0000_8123);

        applyStimulus(RW_WRITE, DT_BYTE, 1'b0, 32'h12, 32'h0000_00AA, 0, 1'b0);
        applyStimulus(RW_READ,  DT_WORD, 1'b0, 32'h10, 32'h0, 0, 1'b0);
        checkOutput("tp_byte_wr", rdata, 32'h8123_AAF6);
        applyStimulus(RW_READ,  DT_WORD, 1'b0, 32'h210, 32'h0, 0, 1'b0);
        checkOutput("tp_wrap", rdata, 32'h8123_AAF6);

        applyStimulus(RW_WRITE, DT_WORD, 1'b0, 32'h11, 32'hDEAD_BEEF, 0, 1'b0);
`ifdef MEM_CTRL_ALIGN_CHECK_EN
        checkOutput("tp_misal_err", {31'b0, align_err}, 32'd1);
        checkOutput("tp_misal_rdata", rdata, 32'd0);
        applyStimulus(RW_READ,  DT_WORD, 1'b0, 32'h10, 32'h0, 0, 1'b0);
        checkOutput("tp_misal_nowr", rdata, 32'h8123_AAF6);
`else
        checkOutput("tp_misal_err", {31'b0, align_err}, 32'd0);
        applyStimulus(RW_READ,  DT_WORD, 1'b0, 32'h10, 32'h0, 0, 1'b0);
        checkOutput("tp_misal_down", rdata, 32'hDEAD_BEEF);
`endif

        applyStimulus(RW_READ, DT_WORD, 1'b0, 32'h10, 32'h0, 5, 1'b0);
        applyStimulus(RW_READ, DT_BYTE, 1'b0, 32'h13, 32'h0, 0, 1'b1);

        // Reset while the write is still counting down in WAIT.
        @(negedge clk);
        rw = RW_WRITE; dtype = DT_WORD; sign = 1'b0; addr = 32'h20; wdata = 32'h0BAD_F00D; mov = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        mov = 1'b0;
        #1;
        exp_rdata = '0;
        exp_err   = 1'b0;
        checkOutput("midrst_moc", {31'b0, moc}, 32'd0);
        checkOutput("midrst_rdata", rdata, 32'd0);
        @(negedge clk);
        clr = 1'b1;
        applyStimulus(RW_READ, DT_WORD, 1'b0, 32'h20, 32'h0, 0, 1'b0);

        for (int t = 0; t < 250; t++)
            applyStimulus(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom,
                          int'($urandom_range(0, 2)), ($urandom_range(0, 3) == 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
